mem_sdp_clr: RTL and testbench

//  Parametrised simple-dual-port RAM (1 write port, 1 read port, one clock), next generation of
//  the pipeline CPU data/instruction store. Adds configurable width/depth, selectable

---
 rtl/mem_sdp_clr.sv | 79 +++++++
 tb/tb_mem_sdp_clr.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_sdp_clr.sv
// mem_sdp_clr: simple-dual-port RAM with read-during-write mode, optional output register and bulk clear engine
module mem_sdp_clr #(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 9,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(16'hFF),
    parameter bit              RDW_MODE = 1'b0,
    parameter bit              OUT_REG  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              re,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic              clr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              rej
);
    localparam int DEPTH = 2**ADDR_W;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};
    logic [DATA_W-1:0] s1_data, rd_word, wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              s1_vld, idle, we_ok, re_ok, wr_en;
    assign idle    = state == IDLE;
    assign busy    = !idle;
    // clr takes priority over a same-cycle user write
    assign we_ok   = idle && we && !clr;
    assign re_ok   = idle && re;
    assign wr_en   = !idle || we_ok;
    assign wr_addr = idle ? w_addr : clr_addr;
    assign wr_data = idle ? data_in : INIT_VAL;
    assign rd_word = (RDW_MODE && we_ok && w_addr == r_addr) ? data_in : mem[r_addr];
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            clr_addr <= '0;
            s1_data  <= INIT_VAL;
            s1_vld   <= 1'b0;
            rej      <= 1'b0;
        end else begin
            rej    <= !idle && (we || re);
            s1_vld <= re_ok;
            if (re_ok) s1_data <= rd_word;
            if (idle) begin
                if (clr) state <= CLEAR;
            end else begin
                clr_addr <= clr_addr + 1'b1;
                if (&clr_addr) state <= IDLE;
            end
        end
    end
    if (OUT_REG) begin : g_out
        logic [DATA_W-1:0] q;
        logic              v;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= INIT_VAL;
                v <= 1'b0;
            end else begin
                v <= s1_vld;
                if (s1_vld) q <= s1_data;
            end
        end
        assign data_out = q;
        assign rd_valid = v;
    end else begin : g_direct
        assign data_out = s1_data;
        assign rd_valid = s1_vld;
    end
endmodule

// File: tb/tb_mem_sdp_clr.sv
// tb_mem_sdp_clr: directed tests for mem_sdp_clr, default build and RDW_MODE=1/OUT_REG=1 build side by side
module tb_mem_sdp_clr;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        we = 1'b0, re = 1'b0, clr = 1'b0;
    logic [8:0]  w_addr = '0, r_addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] d0, d1;
    logic        v0, v1, b0, b1, j0, j1;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_sdp_clr dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .w_addr(w_addr), .data_in(data_in),
        .re(re), .r_addr(r_addr), .clr(clr),
        .data_out(d0), .rd_valid(v0), .busy(b0), .rej(j0)
    );

    mem_sdp_clr #(.RDW_MODE(1'b1), .OUT_REG(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .w_addr(w_addr), .data_in(data_in),
        .re(re), .r_addr(r_addr), .clr(clr),
        .data_out(d1), .rd_valid(v1), .busy(b1), .rej(j1)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        cyc();
        cyc();
        n_tests++; if (d0 !== 16'h00FF) begin n_fail++; $display("FAIL reset_d0 got %h exp 00ff", d0); end
        n_tests++; if (d1 !== 16'h00FF) begin n_fail++; $display("FAIL reset_d1 got %h exp 00ff", d1); end
        n_tests++; if ({v0, b0, j0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags0 got %b exp 000", {v0, b0, j0}); end
        n_tests++; if ({v1, b1, j1} !== 3'b000) begin n_fail++; $display("FAIL reset_flags1 got %b exp 000", {v1, b1, j1}); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_post_reset_reads;
        for (int a = 0; a < 4; a++) begin
            re = 1'b1; r_addr = a[8:0];
            cyc();
            n_tests++; if (d0 !== 16'h00FF || v0 !== 1'b1) begin n_fail++; $display("FAIL init_read%0d got %h/%b exp 00ff/1", a, d0, v0); end
            n_tests++; if (v1 !== (a != 0)) begin n_fail++; $display("FAIL init_read%0d_v1 got %b exp %b", a, v1, a != 0); end
        end
        re = 1'b0;
        cyc();
        n_tests++; if (v0 !== 1'b0 || v1 !== 1'b1 || d1 !== 16'h00FF) begin n_fail++; $display("FAIL init_tail got v0=%b v1=%b d1=%h exp 0/1/00ff", v0, v1, d1); end
        cyc();
        n_tests++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL init_tail_v1 got %b exp 0", v1); end
    endtask

    task automatic test_write_read;
        we = 1'b1; w_addr = 9'd5; data_in = 16'hA5A5;
        cyc();
        we = 1'b0; re = 1'b1; r_addr = 9'd5;
        cyc();
        re = 1'b0;
        n_tests++; if (d0 !== 16'hA5A5 || v0 !== 1'b1) begin n_fail++; $display("FAIL wr_rd_d0 got %h/%b exp a5a5/1", d0, v0); end
        n_tests++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL wr_rd_v1_early got %b exp 0", v1); end
        cyc();
        n_tests++; if (d0 !== 16'hA5A5 || v0 !== 1'b0) begin n_fail++; $display("FAIL wr_rd_hold got %h/%b exp a5a5/0", d0, v0); end
        n_tests++; if (d1 !== 16'hA5A5 || v1 !== 1'b1) begin n_fail++; $display("FAIL wr_rd_d1 got %h/%b exp a5a5/1", d1, v1); end
        cyc();
    endtask

    task automatic test_collision;
        we = 1'b1; w_addr = 9'd7; data_in = 16'h1234; re = 1'b1; r_addr = 9'd7;
        cyc();
        we = 1'b0;
        n_tests++; if (d0 !== 16'h00FF) begin n_fail++; $display("FAIL rdw_old got %h exp 00ff", d0); end
        cyc();
        re = 1'b0;
        n_tests++; if (d0 !== 16'h1234) begin n_fail++; $display("FAIL rdw_after0 got %h exp 1234", d0); end
        n_tests++; if (d1 !== 16'h1234 || v1 !== 1'b1) begin n_fail++; $display("FAIL rdw_new got %h/%b exp 1234/1", d1, v1); end
        cyc();
        n_tests++; if (d1 !== 16'h1234) begin n_fail++; $display("FAIL rdw_after1 got %h exp 1234", d1); end
    endtask

    task automatic test_back_to_back;
        for (int a = 10; a < 14; a++) begin
            we = 1'b1; w_addr = a[8:0]; data_in = 16'hC000 | 16'(a);
            cyc();
        end
        we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            re = 1'b1; r_addr = 9'(10 + i);
            cyc();
            n_tests++; if (d0 !== (16'hC000 | 16'(10 + i)) || v0 !== 1'b1) begin n_fail++; $display("FAIL b2b_d0_%0d got %h exp %h", i, d0, 16'hC000 | 16'(10 + i)); end
            if (i > 0) begin
                n_tests++; if (d1 !== (16'hC000 | 16'(9 + i)) || v1 !== 1'b1) begin n_fail++; $display("FAIL b2b_d1_%0d got %h exp %h", i, d1, 16'hC000 | 16'(9 + i)); end
            end
        end
        re = 1'b0;
        cyc();
        n_tests++; if (d1 !== 16'hC00D || v1 !== 1'b1) begin n_fail++; $display("FAIL b2b_d1_last got %h exp c00d", d1); end
        cyc();
    endtask

    task automatic test_clear;
        int cnt;
        logic [8:0] chk [5] = '{9'd0, 9'd3, 9'd200, 9'd511, 9'd100};
        for (int a = 0; a < 512; a++) begin
            we = 1'b1; w_addr = a[8:0]; data_in = 16'(a);
            cyc();
        end
        we = 1'b0; re = 1'b1; r_addr = 9'd100;
        cyc();
        re = 1'b0;
        n_tests++; if (d0 !== 16'h0064) begin n_fail++; $display("FAIL fill_read got %h exp 0064", d0); end
        clr = 1'b1; we = 1'b1; w_addr = 9'd3; data_in = 16'hBEEF; re = 1'b1; r_addr = 9'd100;
        cyc();
        clr = 1'b0; we = 1'b0; re = 1'b0;
        n_tests++; if (b0 !== 1'b1 || j0 !== 1'b0) begin n_fail++; $display("FAIL clr_start got busy=%b rej=%b exp 1/0", b0, j0); end
        n_tests++; if (d0 !== 16'h0064 || v0 !== 1'b1) begin n_fail++; $display("FAIL clr_same_read got %h/%b exp 0064/1", d0, v0); end
        cnt = 1;
        while (b0 === 1'b1 && cnt < 600) begin
            clr = (cnt == 250);
            we = (cnt == 300); re = (cnt == 300);
            w_addr = 9'd200; data_in = 16'hDEAD; r_addr = 9'd5;
            cyc();
            cnt++;
            if (cnt == 2) begin
                n_tests++; if (d1 !== 16'h0064 || v1 !== 1'b1 || v0 !== 1'b0) begin n_fail++; $display("FAIL clr_pipe_read got d1=%h v1=%b v0=%b exp 0064/1/0", d1, v1, v0); end
            end
            if (cnt == 251) begin
                n_tests++; if (j0 !== 1'b0) begin n_fail++; $display("FAIL clr_ignored_rej got %b exp 0", j0); end
            end
            if (cnt == 301) begin
                n_tests++; if (j0 !== 1'b1 || j1 !== 1'b1 || v0 !== 1'b0) begin n_fail++; $display("FAIL busy_rej got rej=%b/%b v0=%b exp 1/1/0", j0, j1, v0); end
            end
            if (cnt == 302) begin
                n_tests++; if (j0 !== 1'b0) begin n_fail++; $display("FAIL busy_rej_pulse got %b exp 0", j0); end
            end
        end
        clr = 1'b0; we = 1'b0; re = 1'b0;
        n_tests++; if (cnt !== 513) begin n_fail++; $display("FAIL busy_len got %0d exp 512", cnt - 1); end
        n_tests++; if (b1 !== 1'b0) begin n_fail++; $display("FAIL busy1_end got %b exp 0", b1); end
        for (int i = 0; i < 5; i++) begin
            re = 1'b1; r_addr = chk[i];
            cyc();
            n_tests++; if (d0 !== 16'h00FF || v0 !== 1'b1) begin n_fail++; $display("FAIL cleared_%0d got %h/%b exp 00ff/1", chk[i], d0, v0); end
        end
        re = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_clear;
        we = 1'b1; w_addr = 9'd7; data_in = 16'h1234;
        cyc();
        we = 1'b0; re = 1'b1; r_addr = 9'd7;
        cyc();
        re = 1'b0;
        cyc();
        n_tests++; if (d0 !== 16'h1234 || d1 !== 16'h1234) begin n_fail++; $display("FAIL pre_rst got %h/%h exp 1234", d0, d1); end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (99) cyc();
        n_tests++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL mid_clr_busy got %b exp 1", b0); end
        rst_n = 1'b0;
        #2;
        n_tests++; if (b0 !== 1'b0 || b1 !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy got %b/%b exp 0", b0, b1); end
        n_tests++; if (d0 !== 16'h00FF || d1 !== 16'h00FF || v0 !== 1'b0 || v1 !== 1'b0) begin n_fail++; $display("FAIL async_rst_out got %h/%h %b%b exp 00ff 00", d0, d1, v0, v1); end
        cyc();
        rst_n = 1'b1;
        cyc();
        we = 1'b1; w_addr = 9'd9; data_in = 16'h5A5A;
        cyc();
        we = 1'b0; re = 1'b1; r_addr = 9'd9;
        cyc();
        re = 1'b0;
        n_tests++; if (d0 !== 16'h5A5A || v0 !== 1'b1 || b0 !== 1'b0) begin n_fail++; $display("FAIL post_rst_d0 got %h/%b/%b exp 5a5a/1/0", d0, v0, b0); end
        cyc();
        n_tests++; if (d1 !== 16'h5A5A || v1 !== 1'b1) begin n_fail++; $display("FAIL post_rst_d1 got %h/%b exp 5a5a/1", d1, v1); end
    endtask

    initial begin
        test_reset();
        test_post_reset_reads();
        test_write_read();
        test_collision();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", n_tests);
        $fatal(1, "timeout");
    end
endmodule
